// File: rtl/task_2_out_pkg.sv
// task_2_pkg: shared definitions for the task_2 output stage.
// Holds the output state encoding, default sizing and the counter-width helper.
// The cut-through option is selected in task_2_out.sv via TASK_2_OUT_CUT_THROUGH_EN.
package task_2_pkg;

    typedef enum logic [1:0] {
        s_IDLE,
        s_COLLECT,
        s_DRAIN,
        s_DONE
    } task_output_enum;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_WORDS  = 243;
    localparam int DEF_FIFO_DEPTH = 256;

    // Width of the word counters; they index 0..num_words-1 within one frame.
    function automatic int cnt_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage

// File: rtl/task_2_out_if.sv
// task_2_out_if: groups the core-side write port and the stream-side sink port
// of the task_2 output stage. The master modport is the surrounding system,
// the slave modport is the output stage itself.
interface task_2_out_if
    import task_2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_enb;
    logic                  i_tready;
    logic [DATA_WIDTH-1:0] o_tdata;
    logic                  o_tvalid;
    logic                  o_tlast;
    logic                  o_output_last;
    logic                  o_overflow;

    modport master (
        output i_data,
        output i_enb,
        output i_tready,
        input  o_tdata,
        input  o_tvalid,
        input  o_tlast,
        input  o_output_last,
        input  o_overflow
    );

    modport slave (
        input  i_data,
        input  i_enb,
        input  i_tready,
        output o_tdata,
        output o_tvalid,
        output o_tlast,
        output o_output_last,
        output o_overflow
    );

endinterface

// File: rtl/task_2_sync_fifo.sv
// task_2_sync_fifo: single-clock FIFO used as the frame buffer of the task_2
// output stage. Registered read port (data appears the cycle after rd_en),
// synchronous clear, empty/full flags. Writes when full and reads when empty
// are ignored.
module task_2_sync_fifo
    import task_2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);

    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [COUNT_W-1:0]    count;
    logic                  do_write;
    logic                  do_read;

    assign empty    = (count == '0);
    assign full     = (count == COUNT_W'(FIFO_DEPTH));
    assign do_write = wr_en && !full;
    assign do_read  = rd_en && !empty;

    // Storage array, left without reset so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered read port; clear empties the buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_read) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({do_write, do_read})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/task_2_out.sv
// task_2_out: output stage of the task_2 datapath.
// Buffers one frame of NUM_WORDS processed words from the core, streams it to
// the sink with o_tlast on the final word, then pulses o_output_last so the
// input stage can request the next frame. Words arriving when they cannot be
// stored are dropped and latch o_overflow until reset.
// Build option TASK_2_OUT_CUT_THROUGH_EN: start streaming as soon as the buffer
// holds a word instead of waiting for the whole frame (store-and-forward when
// undefined).
module task_2_out
    import task_2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WORDS  = DEF_NUM_WORDS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input logic         i_clk,
    input logic         i_rst,
    task_2_out_if.slave bus
);

    localparam int               CNT_W    = cnt_width(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

`ifdef TASK_2_OUT_CUT_THROUGH_EN
    localparam bit CUT_THROUGH = 1'b1;
`else
    localparam bit CUT_THROUGH = 1'b0;
`endif

    task_output_enum       state;
    task_output_enum       next_state;
    logic [CNT_W-1:0]      wr_cnt;
    logic [CNT_W-1:0]      rd_cnt;
    logic                  out_valid;
    logic                  overflow;
    logic                  wr_allowed;
    logic                  rd_allowed;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  beat_xfer;
    logic                  tlast;
    logic                  drop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    // The FIFO read register doubles as the output register; out_valid marks
    // whether it currently holds an undelivered word.
    assign beat_xfer = out_valid && bus.i_tready;
    assign tlast     = out_valid && (rd_cnt == LAST_IDX);
    assign wr_fire   = bus.i_enb && wr_allowed && !fifo_full;
    assign drop      = bus.i_enb && !wr_fire;
    assign rd_fire   = rd_allowed && !fifo_empty && (!out_valid || beat_xfer);

    task_2_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en   (wr_fire),
        .wr_data (bus.i_data),
        .rd_en   (rd_fire),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // State register for the collect/drain sequencing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= s_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus which side of the buffer each state lets run.
    always_comb begin
        next_state = state;
        wr_allowed = 1'b0;
        rd_allowed = 1'b0;
        case (state)
            s_IDLE: begin
                wr_allowed = 1'b1;
                rd_allowed = CUT_THROUGH;
                if (bus.i_enb && !fifo_full) begin
                    next_state = s_COLLECT;
                end
            end
            s_COLLECT: begin
                wr_allowed = 1'b1;
                rd_allowed = CUT_THROUGH;
                if (bus.i_enb && !fifo_full && (wr_cnt == LAST_IDX)) begin
                    next_state = s_DRAIN;
                end
            end
            s_DRAIN: begin
                rd_allowed = 1'b1;
                if (beat_xfer && tlast) begin
                    next_state = s_DONE;
                end
            end
            s_DONE: begin
                next_state = s_IDLE;
            end
            default: begin
                next_state = s_IDLE;
            end
        endcase
    end

    // Word counters, output-register occupancy and the sticky drop flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= (wr_cnt == LAST_IDX) ? '0 : wr_cnt + CNT_W'(1);
            end

            if (state == s_DONE) begin
                rd_cnt <= '0;
            end else if (beat_xfer) begin
                rd_cnt <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + CNT_W'(1);
            end

            if (rd_fire) begin
                out_valid <= 1'b1;
            end else if (beat_xfer) begin
                out_valid <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.o_tdata       = fifo_rd_data;
    assign bus.o_tvalid      = out_valid;
    assign bus.o_tlast       = tlast;
    assign bus.o_output_last = (state == s_DONE);
    assign bus.o_overflow    = overflow;

endmodule

// File: tb/tb_task_2_out.sv
// tb_task_2_out: directed self-checking bench for task_2_out with the default
// parameters (8-bit words, 243-word frames, 256-deep buffer). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_task_2_out;

    localparam int DW = 8;
    localparam int NW = 243;
    localparam int FD = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    int cycle = 0;
    int beat_idx;
    int tlast_cnt;
    int ol_cnt;
    int ol_total = 0;
    int bubble_cnt;
    int first_valid_cycle;
    int tlast_cycle;
    int ol_cycle;
    int first_enb_cycle;
    int last_write_cycle;
    int ol_mark;

    logic [DW-1:0] exp_base;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_tdata = '0;
    logic          prev_tlast = 1'b0;
    logic          prev_ol    = 1'b0;

    always #5 clk = ~clk;

    task_2_out_if #(.DATA_WIDTH(DW)) bus ();

    task_2_out #(
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .FIFO_DEPTH (FD)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Observe the current cycle (inputs already set for the coming edge), then advance.
    task automatic tick();
        logic [DW-1:0] exp_word;
        if (prev_stall) begin
            checkOutput("stall_tvalid_hold", bus.o_tvalid, 1);
            checkOutput("stall_tdata_hold", bus.o_tdata, prev_tdata);
            checkOutput("stall_tlast_hold", bus.o_tlast, prev_tlast);
        end
        if (bus.o_tvalid === 1'b1 && first_valid_cycle < 0) first_valid_cycle = cycle;
        if (first_valid_cycle >= 0 && tlast_cnt == 0 && bus.o_tvalid !== 1'b1) bubble_cnt++;
        if (bus.o_tvalid === 1'b1 && bus.i_tready === 1'b1) begin
            exp_word = exp_base + beat_idx[DW-1:0];
            checkOutput("beat_tdata", bus.o_tdata, exp_word);
            checkOutput("beat_tlast", bus.o_tlast, (beat_idx == NW - 1));
            if (bus.o_tlast === 1'b1) begin
                tlast_cnt++;
                tlast_cycle = cycle;
            end
            beat_idx++;
        end
        if (bus.o_output_last === 1'b1) begin
            checkOutput("output_last_width", prev_ol, 0);
            ol_cnt++;
            ol_total++;
            ol_cycle = cycle;
        end
        prev_stall = (bus.o_tvalid === 1'b1) && (bus.i_tready !== 1'b1);
        prev_tdata = bus.o_tdata;
        prev_tlast = bus.o_tlast;
        prev_ol    = bus.o_output_last;
        @(negedge clk);
        cycle++;
    endtask

    task automatic applyStimulus(input logic enb, input logic [DW-1:0] data, input logic tready);
        bus.i_enb    = enb;
        bus.i_data   = data;
        bus.i_tready = tready;
        tick();
    endtask

    task automatic startFrame(input logic [DW-1:0] base);
        exp_base          = base;
        beat_idx          = 0;
        tlast_cnt         = 0;
        ol_cnt            = 0;
        bubble_cnt        = 0;
        first_valid_cycle = -1;
        tlast_cycle       = -1;
        ol_cycle          = -1;
    endtask

    task automatic sendFrame(input logic [DW-1:0] base, input int count, input bit gap);
        for (int i = 0; i < count; i++) begin
            if (i == 0) first_enb_cycle = cycle;
            last_write_cycle = cycle;
            applyStimulus(1'b1, base + i[DW-1:0], 1'b1);
            if (gap) applyStimulus(1'b0, '0, 1'b1);
        end
    endtask

    // Run until o_output_last, optionally toggling tready and injecting stray writes.
    task automatic drainFrame(input bit toggle, input int inj_lo, input int inj_hi);
        int k = 0;
        while (ol_cnt == 0 && k < 2000) begin
            applyStimulus((k >= inj_lo && k <= inj_hi), 8'hEE, toggle ? ((k % 2) == 0) : 1'b1);
            k++;
        end
        checkOutput("drain_finished", (ol_cnt != 0), 1);
    endtask

    task automatic endFrame(input logic exp_ovf);
        checkOutput("frame_beats", beat_idx, NW);
        checkOutput("frame_tlast_count", tlast_cnt, 1);
        checkOutput("frame_output_last_count", ol_cnt, 1);
        checkOutput("frame_overflow", bus.o_overflow, exp_ovf);
    endtask

    task automatic checkReset();
        checkOutput("reset_tvalid", bus.o_tvalid, 0);
        checkOutput("reset_tlast", bus.o_tlast, 0);
        checkOutput("reset_output_last", bus.o_output_last, 0);
        checkOutput("reset_overflow", bus.o_overflow, 0);
        checkOutput("reset_tdata", bus.o_tdata, 0);
    endtask

    // Bound the whole run in case the design stops responding.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence of scenarios.
    initial begin
        bus.i_data   = '0;
        bus.i_enb    = 1'b0;
        bus.i_tready = 1'b1;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        checkReset();
        rst = 1'b0;

        $display("[TB] full frame, sink always ready");
        startFrame(8'h00);
        sendFrame(8'h00, NW, 1'b0);
        drainFrame(1'b0, 1, 0);
        endFrame(1'b0);
`ifndef TASK_2_OUT_CUT_THROUGH_EN
        checkOutput("latency_first_tvalid", first_valid_cycle - last_write_cycle, 2);
        checkOutput("latency_tlast_beat", tlast_cycle - last_write_cycle, NW + 1);
        checkOutput("latency_output_last", ol_cycle - last_write_cycle, NW + 2);
`endif

        $display("[TB] full frame, sink ready toggling");
        startFrame(8'h00);
        sendFrame(8'h00, NW, 1'b0);
        drainFrame(1'b1, 1, 0);
        endFrame(1'b0);

        $display("[TB] stray writes while draining");
        startFrame(8'h20);
        sendFrame(8'h20, NW, 1'b0);
        drainFrame(1'b0, 3, 7);
        endFrame(1'b1);
        repeat (4) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("overflow_sticky", bus.o_overflow, 1);

        $display("[TB] reset in the middle of a frame");
        startFrame(8'h00);
        sendFrame(8'h00, 100, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkReset();
        rst = 1'b0;
        checkOutput("no_output_last_partial", ol_cnt, 0);
        startFrame(8'h10);
        sendFrame(8'h10, NW, 1'b0);
        drainFrame(1'b0, 1, 0);
        endFrame(1'b0);

        $display("[TB] back-to-back frames");
        ol_mark = ol_total;
        startFrame(8'h40);
        sendFrame(8'h40, NW, 1'b0);
        drainFrame(1'b0, 1, 0);
        endFrame(1'b0);
        startFrame(8'h99);
        sendFrame(8'h99, NW, 1'b0);
        drainFrame(1'b0, 1, 0);
        endFrame(1'b0);
        checkOutput("back_to_back_pulses", ol_total - ol_mark, 2);

`ifdef TASK_2_OUT_CUT_THROUGH_EN
        $display("[TB] cut-through with writes every other cycle");
        startFrame(8'h00);
        sendFrame(8'h00, NW, 1'b1);
        drainFrame(1'b0, 1, 0);
        endFrame(1'b0);
        checkOutput("ct_first_beat_latency", first_valid_cycle - first_enb_cycle, 2);
        checkOutput("ct_bubbles_present", (bubble_cnt > 0), 1);
`endif

        applyStimulus(1'b0, '0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/task_2_out.md
Name: task_2_out

Overview:
Output stage of the task_2 datapath, directly downstream of the processing core.
- Collects the processed words the core emits (i_data qualified by i_enb) into a frame buffer.
- Streams the frame to the external AXI-Stream-like sink, with o_tlast on the final word.
- Pulses o_output_last when the sink has accepted the whole frame; the input stage uses this pulse to request the next frame.

Parameters:
DATA_WIDTH, 8, width of core data and output stream words
NUM_WORDS, 243, words per frame; must be >= 2
FIFO_DEPTH, 256, buffer depth; power of two, >= NUM_WORDS

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  reset, synchronous, active-high
i_data  in  DATA_WIDTH  processed word from core
i_enb  in  1  i_data valid this cycle; no backpressure towards core
i_tready  in  1  sink ready
o_tdata  out  DATA_WIDTH  stream data
o_tvalid  out  1  stream valid
o_tlast  out  1  final word of frame; qualified by o_tvalid
o_output_last  out  1  one-cycle pulse: frame fully delivered
o_overflow  out  1  sticky error flag: a word was dropped

Behaviour:
- Reset (i_rst=1 on a clock edge), all outputs 0:
  - o_tvalid, o_tlast, o_output_last, o_overflow, o_tdata = 0.
  - FIFO flushed; wr_cnt = rd_cnt = 0; state = s_IDLE.
  - Reset mid-frame discards the partial frame and issues no o_output_last.
- Beat transfer: a beat transfers on a cycle with o_tvalid && i_tready.
  - While o_tvalid=1 and i_tready=0, o_tdata, o_tlast and o_tvalid hold.
  - o_tvalid never depends combinationally on i_tready.
- Counters: wr_cnt and rd_cnt are $clog2(NUM_WORDS) bits and wrap to 0 after NUM_WORDS-1.
- State machine (all transitions registered):
  - s_IDLE: i_enb writes the word, wr_cnt++, go to s_COLLECT. With NUM_WORDS=1 disallowed, the frame cannot complete in s_IDLE.
  - s_COLLECT: each i_enb writes and increments wr_cnt. When i_enb is high with wr_cnt==NUM_WORDS-1, wr_cnt wraps to 0 and the next state is s_DRAIN.
  - s_DRAIN: a FIFO read fills the output register whenever the register is empty or its beat transfers this cycle, and the FIFO is non-empty.
    - The read is pipelined so that, with i_tready held high, the sink accepts one beat per cycle.
    - o_tlast = 1 when the registered word has rd_cnt==NUM_WORDS-1.
    - When the tlast beat transfers, go to s_DONE.
  - s_DONE: o_output_last=1 for exactly this one cycle; rd_cnt=0; go to s_IDLE.
- Latency:
  - Last write on cycle N, i_tready=1 throughout: o_tvalid=1 at cycle N+2.
  - The tlast beat transfers at N+1+NUM_WORDS.
  - o_output_last is high during cycle N+2+NUM_WORDS.
- Word dropping: i_enb in s_DRAIN or s_DONE is dropped, the FIFO is not written, and o_overflow sets and stays set until reset. A write while the FIFO is full is handled the same way.
- Simultaneous events: in s_DONE, o_output_last and a dropped i_enb may coincide; o_overflow still sets.

Optional Feature:
Macro TASK_2_OUT_CUT_THROUGH_EN.
- Defined:
  - Draining starts as soon as the FIFO is non-empty, from s_IDLE or s_COLLECT; there is no s_DRAIN wait for the full frame.
  - The collect and drain sides run concurrently.
  - o_tvalid may drop mid-frame when the FIFO runs empty (bubble).
  - o_tlast and o_output_last timing are still tied to rd_cnt.
  - First-beat latency is 2 cycles after the first i_enb.
  - i_enb of the next frame is accepted only after o_output_last; earlier i_enb sets o_overflow.
- Undefined: store-and-forward as described in Behaviour.

Decomposition:
- Package task_2_pkg holds:
  - typedef enum task_output_enum {s_IDLE, s_COLLECT, s_DRAIN, s_DONE};
  - function/localparam for counter width, $clog2(NUM_WORDS).
- Sub-module task_2_sync_fifo:
  - Inferred single-clock FIFO: read latency 1, synchronous clear, empty/full outputs.
  - Parameterised DATA_WIDTH and FIFO_DEPTH.

Test Plan:
- Reset, then 243 consecutive i_enb with data 0..242 and i_tready=1 → o_tvalid high from cycle N+2; o_tdata sequence 0..242; o_tlast only on 242; o_output_last one pulse at N+245; o_overflow=0.
- Same frame, i_tready toggling 1,0,1,0 → o_tdata held stable in every stalled cycle; 243 beats delivered in order; exactly one o_tlast.
- Five i_enb pulses during s_DRAIN → o_overflow=1 and stays 1; the output stream is still exactly the original 243 words.
- i_rst asserted after 100 of 243 writes, then a full new frame 0x10.. → only the new frame appears; exactly one o_output_last.
- Two back-to-back frames, second starting the cycle after o_output_last → both delivered intact; two o_output_last pulses; no overflow.
- TASK_2_OUT_CUT_THROUGH_EN defined, i_enb every other cycle → first o_tvalid 2 cycles after the first i_enb; bubbles present; o_tlast on word 243.
